// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage load/store controller with req/ack data bus
//
// Purpose: converts M-stage load/store control into a single req/ack bus
// transaction, stalls the pipeline until it completes (or times out), steers
// byte/halfword lanes for stores and extracts/extends lanes for loads.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   - misaligned half/word accesses skip the bus and raise BusErrM
//   undefined - illegal low address bits are forced to zero, access proceeds
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   MemReadM, MemWriteM          M-stage load / store (both high = store)
//   MemSizeM, MemSignedM         access size (00 b, 01 h, 1x w), load sign
//   ALUOutM, WriteDataM          byte address, right-justified store data
//   ReadDataM                    extended load data, valid in DONE
//   StallM                       pipeline freeze
//   BusErrM                      one-cycle error pulse
//   mem_req/we/addr/be/wdata     registered bus request
//   mem_rdata, mem_ack           bus response

module mem_stage_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  MemSizeM,
    input  logic        MemSignedM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        BusErrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [1:0]        lo_q, lo_d;

    logic              access;
    logic              trap;
    logic [1:0]        lo_eff;
    logic [3:0]        be_new;
    logic [31:0]       wdata_new;

    assign access = MemReadM | MemWriteM;

`ifdef MISALIGN_TRAP_EN
    assign trap = ((MemSizeM == 2'b01) && ALUOutM[0]) ||
                  (MemSizeM[1] && (ALUOutM[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // Low address bits after dropping those that are illegal for the size.
    always_comb begin
        lo_eff = 2'b00;
        case (MemSizeM)
            2'b00:   lo_eff = ALUOutM[1:0];
            2'b01:   lo_eff = {ALUOutM[1], 1'b0};
            default: lo_eff = 2'b00;
        endcase
    end

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = WriteDataM;
        case (MemSizeM)
            2'b00: begin
                be_new    = 4'b0001 << lo_eff;
                wdata_new = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be_new    = lo_eff[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{WriteDataM[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = WriteDataM;
            end
        endcase
    end

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] sz,
                                                input logic sg, input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   return {{24{sg & b[7]}}, b};
            2'b01:   return {{16{sg & h[15]}}, h};
            default: return w;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        size_d   = size_q;
        signed_d = signed_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (access && trap) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end else if (access) begin
                    state_d  = S_REQ;
                    req_d    = 1'b1;
                    we_d     = MemWriteM;
                    addr_d   = {ALUOutM[31:2], 2'b00};
                    be_d     = be_new;
                    wdata_d  = wdata_new;
                    cnt_d    = '0;
                    size_d   = MemSizeM;
                    signed_d = MemSignedM;
                    lo_d     = lo_eff;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                // Ack is checked first so a same-cycle ack beats the timeout.
                if (mem_ack) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    rdata_d = load_extend(mem_rdata, size_q, signed_q, lo_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end
            end
            // The instruction is still visible in M here; never restart.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            lo_q     <= 2'b00;
        end else begin
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            lo_q     <= lo_d;
        end
    end

    assign StallM    = !rst && ((state_q == S_IDLE) ? access : (state_q == S_REQ));
    assign ReadDataM = (!rst && (state_q == S_DONE)) ? rdata_q : 32'h0;
    assign BusErrM   = err_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed self-checking bench for mem_stage_ctrl

module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM, MemSignedM;
    logic [1:0]  MemSizeM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, BusErrM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ack;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_ctrl #(.ACK_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemSizeM(MemSizeM),
        .MemSignedM(MemSignedM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .BusErrM(BusErrM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Called #1 after a posedge with the controller in IDLE.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int ack_cyc, input logic [31:0] rdat,
                              input int exp_req, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic exp_we,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_rd,
                              input logic exp_err);
        int  stall_n = 0;
        int  req_n   = 0;
        int  err_n   = 0;
        bit  done    = 0;
        MemReadM = rd; MemWriteM = wr; MemSizeM = sz; MemSignedM = sg;
        ALUOutM = a; WriteDataM = wd;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = 32'h0;
            if (BusErrM) err_n++;
            if (mem_req) begin
                req_n++;
                if (req_n == 1) begin
                    check({tag, "_addr"}, mem_addr, exp_addr);
                    check({tag, "_be"}, {28'h0, mem_be}, {28'h0, exp_be});
                    check({tag, "_we"}, {31'h0, mem_we}, {31'h0, exp_we});
                    check({tag, "_wdata"}, mem_wdata, exp_wdata);
                end
                if (req_n == ack_cyc) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdat;
                end
            end
            if (StallM) begin
                stall_n++;
            end else begin
                done = 1;
                check({tag, "_rdata"}, ReadDataM, exp_rd);
                check({tag, "_buserr"}, {31'h0, BusErrM}, {31'h0, exp_err});
                MemReadM = 1'b0; MemWriteM = 1'b0;
            end
            @(posedge clk); #1;
        end
        check({tag, "_done"}, {31'h0, done}, 32'h1);
        check({tag, "_stall_cycles"}, stall_n, exp_req + 1);
        check({tag, "_req_cycles"}, req_n, exp_req);
        check({tag, "_err_cycles"}, err_n, {31'h0, exp_err});
        @(negedge clk);
        check({tag, "_idle_stall"}, {31'h0, StallM}, 32'h0);
        check({tag, "_idle_req"}, {31'h0, mem_req}, 32'h0);
        check({tag, "_idle_rdata"}, ReadDataM, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; MemSizeM = 2'b10;
        MemSignedM = 1'b0; ALUOutM = 32'h100; WriteDataM = 32'h0;
        mem_rdata = 32'h0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'h0, StallM}, 32'h0);
        check("rst_req", {31'h0, mem_req}, 32'h0);
        check("rst_rdata", ReadDataM, 32'h0);
        check("rst_buserr", {31'h0, BusErrM}, 32'h0);
        check("rst_be", {28'h0, mem_be}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; MemReadM = 1'b0;
        @(posedge clk); #1;

        run_access("ldw", 1, 0, 2'b10, 0, 32'h100, 32'h0, 2, 32'hDEADBEEF,
                   2, 32'h100, 4'b1111, 0, 32'h0, 32'hDEADBEEF, 0);
        run_access("ldb_s", 1, 0, 2'b00, 1, 32'h203, 32'h0, 1, 32'h80112233,
                   1, 32'h200, 4'b1000, 0, 32'h0, 32'hFFFFFF80, 0);
        run_access("ldb_u", 1, 0, 2'b00, 0, 32'h203, 32'h0, 1, 32'h80112233,
                   1, 32'h200, 4'b1000, 0, 32'h0, 32'h00000080, 0);
        run_access("sth", 0, 1, 2'b01, 0, 32'h12, 32'h0000ABCD, 1, 32'h0,
                   1, 32'h10, 4'b1100, 1, 32'hABCDABCD, 32'h0, 0);
        run_access("stb", 0, 1, 2'b00, 0, 32'h5, 32'h12345678, 1, 32'h0,
                   1, 32'h4, 4'b0010, 1, 32'h78787878, 32'h0, 0);
        run_access("ldh_s", 1, 0, 2'b01, 1, 32'h2, 32'h0, 1, 32'h80011234,
                   1, 32'h0, 4'b1100, 0, 32'h0, 32'hFFFF8001, 0);
        run_access("ldh_u", 1, 0, 2'b01, 0, 32'h8, 32'h0, 3, 32'h12348765,
                   3, 32'h8, 4'b0011, 0, 32'h0, 32'h00008765, 0);
        run_access("rdwr", 1, 1, 2'b11, 0, 32'h20, 32'hCAFEF00D, 1, 32'h0,
                   1, 32'h20, 4'b1111, 1, 32'hCAFEF00D, 32'h0, 0);
        run_access("tmo", 1, 0, 2'b10, 0, 32'h300, 32'h0, 0, 32'h0,
                   4, 32'h300, 4'b1111, 0, 32'h0, 32'h0, 1);
        run_access("ack_last", 1, 0, 2'b10, 0, 32'h304, 32'h0, 4, 32'h55AA1234,
                   4, 32'h304, 4'b1111, 0, 32'h0, 32'h55AA1234, 0);
`ifdef MISALIGN_TRAP_EN
        run_access("misw", 1, 0, 2'b10, 0, 32'h102, 32'h0, 1, 32'h01020304,
                   0, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 1);
        run_access("mish", 1, 0, 2'b01, 0, 32'h13, 32'h0, 1, 32'hBEEF0000,
                   0, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 1);
`else
        run_access("misw", 1, 0, 2'b10, 0, 32'h102, 32'h0, 1, 32'h01020304,
                   1, 32'h100, 4'b1111, 0, 32'h0, 32'h01020304, 0);
        run_access("mish", 1, 0, 2'b01, 0, 32'h13, 32'h0, 1, 32'hBEEF0000,
                   1, 32'h10, 4'b1100, 0, 32'h0, 32'h0000BEEF, 0);
`endif

        // Reset asserted during the second REQ cycle, then a late ack.
        MemReadM = 1'b1; MemWriteM = 1'b0; MemSizeM = 2'b10; ALUOutM = 32'h400;
        @(negedge clk);
        check("rreq_idle_stall", {31'h0, StallM}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rreq_req1", {31'h0, mem_req}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rreq_stall_in_rst", {31'h0, StallM}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; MemReadM = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("rreq_req_dropped", {31'h0, mem_req}, 32'h0);
        check("rreq_stall", {31'h0, StallM}, 32'h0);
        check("rreq_rdata", ReadDataM, 32'h0);
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        check("rreq_late_req", {31'h0, mem_req}, 32'h0);
        check("rreq_late_err", {31'h0, BusErrM}, 32'h0);
        check("rreq_late_rdata", ReadDataM, 32'h0);
        check("rreq_late_stall", {31'h0, StallM}, 32'h0);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller between the EtoM and MtoW pipeline registers.
- Turns the M-stage load/store control and address into a req/ack transaction on the data-memory bus, and stalls the pipeline until the bus completes.
- Handles byte and halfword lane steering and load sign/zero extension.
- Delivers ReadDataM ready for MtoW to capture on the release cycle.

Parameters:
- ACK_TIMEOUT, 255: maximum cycles REQ waits for mem_ack before aborting; 1..65535.
- CNT_W, 16: width of the timeout counter; must hold ACK_TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- MemReadM  in  1  load in M stage
- MemWriteM  in  1  store in M stage
- MemSizeM  in  2  00 byte, 01 half, 10 word, 11 treated as word
- MemSignedM  in  1  loads: 1 sign-extend, 0 zero-extend
- ALUOutM  in  32  effective byte address
- WriteDataM  in  32  store data, right-justified
- ReadDataM  out  32  extended load data, valid in DONE
- StallM  out  1  freeze F/D/E/M stages and EtoM, MtoW
- BusErrM  out  1  one-cycle pulse when a transaction times out
- mem_req  out  1  bus request, registered
- mem_we  out  1  1 store, 0 load
- mem_addr  out  32  word address, {ALUOutM[31:2],2'b00}
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read word, valid with mem_ack
- mem_ack  in  1  completion, single-cycle

Behaviour:
- Reset, synchronous: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, captured data=0, counter=0, BusErrM=0.
- While in reset: ReadDataM=0 and StallM=0.
- Access = MemReadM|MemWriteM. If both are high, treat as a store.
- FSM states:
  - IDLE: StallM = access, combinationally. On access, register mem_addr/mem_we/mem_be/mem_wdata, set mem_req=1, clear counter, go to REQ. With no access, stay in IDLE with StallM=0.
  - REQ: StallM=1 and mem_req held at 1 with stable bus outputs; counter increments each cycle.
    - On mem_ack: capture mem_rdata, drop mem_req next cycle, go to DONE.
    - If counter reaches ACK_TIMEOUT-1 without ack: drop mem_req, pulse BusErrM for one cycle, captured data=0, go to DONE.
    - If ack arrives in the same cycle as the timeout, ack wins and no BusErrM.
  - DONE: StallM=0 and ReadDataM driven from captured data; the pipeline advances on this edge. Always go to IDLE.
- DONE never restarts a transaction, even though the same instruction is still visible in M that cycle.
- Minimum latency for a load/store: 3 cycles (IDLE, REQ with ack in the first cycle, DONE).
- mem_ack outside REQ is ignored.
- Byte enables: byte = 1<<a[1:0]; half = a[1]?1100:0011; word = 1111.
- mem_wdata: byte replicates WriteDataM[7:0] ×4; half replicates [15:0] ×2; word passes through.
- Load extract: byte takes lane a[1:0], half takes lane a[1]; extend per MemSignedM to 32 bits. Word passes through.
- ReadDataM = 0 in any state other than DONE.
- rst in REQ aborts the transaction: mem_req=0 on the next edge, no BusErrM, and any ack that follows is ignored.
- Misalignment (half with a[0]=1; word with a[1:0]≠0) is handled per the optional feature below.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access does not enter REQ.
  - IDLE goes directly to DONE, with BusErrM pulsing in the DONE cycle and captured data=0.
  - No bus activity; stall lasts 1 cycle.
- Undefined: low address bits that are illegal for the size are forced to 0 (half uses a[0]=0; word uses a[1:0]=00) and the access proceeds normally. BusErrM is driven only by timeout.

Test Plan:
- Word load: addr 0x100, mem_rdata=0xDEADBEEF with ack 2 cycles after req → StallM high 3 cycles, then ReadDataM=0xDEADBEEF in DONE; mem_be=1111, mem_addr=0x100.
- Signed byte load: addr 0x203, rdata=0x80112233 → mem_be=1000, ReadDataM=0xFFFFFF80. Same with MemSignedM=0 → 0x00000080.
- Half store: addr 0x12, WriteDataM=0x0000ABCD → mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x10, ack in the first REQ cycle → 3-cycle access.
- Timeout: ACK_TIMEOUT=4, never ack → mem_req high 4 cycles, BusErrM one-cycle pulse, ReadDataM=0 in DONE, return to IDLE.
- Reset mid-REQ: rst asserted on REQ cycle 2 → next edge mem_req=0, StallM=0, state IDLE. A late ack has no effect.
- Misaligned word load at 0x102: with MISALIGN_TRAP_EN → no mem_req, BusErrM in the next cycle. Without it → mem_addr=0x100, mem_be=1111, normal completion.
